// File: rtl/beep_pkg.sv
// Shared types and elaboration helpers for the beep pattern player.
// Optional feature macro used by the top: BEEP_QUEUE_EN.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int cyc_from_ms(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int half_period(input int clk_freq, input int tone_hz);
        return clk_freq / (2 * tone_hz);
    endfunction

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int width_of(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/beep_pattern_player_tone_divider.sv
// Square-wave generator: HALF-cycle half-period, starts high on restart,
// held low while disabled.
import beep_pkg::*;

module tone_divider #(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic sq
);

    localparam int             PW      = width_of(HALF - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

    logic [PW-1:0] r_ph;
    logic          r_sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph <= '0;
            r_sq <= 1'b0;
        end else if (restart) begin
            r_ph <= '0;
            r_sq <= 1'b1;
        end else if (!en) begin
            r_ph <= '0;
            r_sq <= 1'b0;
        end else if (r_ph == PH_LAST) begin
            r_ph <= '0;
            r_sq <= ~r_sq;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    assign sq = r_sq;

endmodule

// File: rtl/beep_pattern_player.sv
// Plays NUM_BEEPS tone bursts with silent gaps for each debounced key press.
// Define BEEP_QUEUE_EN to remember one press made while a pattern is playing.
import beep_pkg::*;

module beep_pattern_player #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TONE_HZ   = 2_000,
    parameter int BEEP_MS   = 100,
    parameter int GAP_MS    = 100,
    parameter int NUM_BEEPS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_value,
    output logic beep,
    output logic busy
);

    localparam int HALF     = half_period(CLK_FREQ, TONE_HZ);
    localparam int BEEP_CYC = cyc_from_ms(CLK_FREQ, BEEP_MS);
    localparam int GAP_CYC  = cyc_from_ms(CLK_FREQ, GAP_MS);
    localparam int MAX_CYC  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int CW       = width_of(MAX_CYC - 1);
    localparam int IW       = width_of(NUM_BEEPS - 1);

    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BEEPS - 1);

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_n;
    logic          r_pend;
    logic          w_pend_n;
    logic          r_seam;
    logic          w_seam_n;
    logic          r_busy;
    logic          w_trig;
    logic          w_replay;
    logic          w_en;
    logic          w_restart;

    assign w_trig = key_flag & ~key_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_seam  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_pend  <= w_pend_n;
            r_seam  <= w_seam_n;
            r_busy  <= (w_state_n != IDLE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_seam_n  = 1'b0;
        w_en      = 1'b0;
        w_restart = 1'b0;
`ifdef BEEP_QUEUE_EN
        w_pend_n  = r_pend | (w_trig & (r_state != IDLE));
        w_replay  = w_pend_n;
`else
        w_pend_n  = 1'b0;
        w_replay  = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_n = TONE;
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_restart = 1'b1;
                end
            end
            TONE: begin
                // One silent cycle between a finished pattern and its replay.
                if (r_seam) begin
                    w_cnt_n   = '0;
                    w_restart = 1'b1;
                end else if (r_cnt == BEEP_LAST) begin
                    w_cnt_n = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_n = '0;
                        if (w_replay) begin
                            w_seam_n = 1'b1;
                            w_pend_n = 1'b0;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_state_n = GAP;
                        w_idx_n   = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                    w_en    = 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_n = TONE;
                    w_cnt_n   = '0;
                    w_restart = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
                w_idx_n   = '0;
            end
        endcase
    end

    tone_divider #(
        .HALF(HALF)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .restart(w_restart),
        .sq     (beep)
    );

    assign busy = r_busy;

endmodule

// File: tb/tb_beep_pattern_player.sv
// Bench for beep_pattern_player: a two-beep and a one-beep instance checked
// each cycle against a pattern-offset reference model.
`timescale 1ns/1ps
module tb_beep_pattern_player;

    localparam int CF   = 10_000;
    localparam int TH   = 1_000;
    localparam int BMS  = 2;
    localparam int GMS  = 1;
    localparam int HALF = 5;
    localparam int BEEP = 20;
    localparam int GAP  = 10;
`ifdef BEEP_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] kf  = 2'b00;
    logic [1:0] kv  = 2'b11;
    logic [1:0] bp;
    logic [1:0] bz;

    always #5 clk = ~clk;

    beep_pattern_player #(
        .CLK_FREQ(CF), .TONE_HZ(TH), .BEEP_MS(BMS), .GAP_MS(GMS), .NUM_BEEPS(2)
    ) u0 (
        .clk(clk), .rst(rst), .key_flag(kf[0]), .key_value(kv[0]),
        .beep(bp[0]), .busy(bz[0])
    );

    beep_pattern_player #(
        .CLK_FREQ(CF), .TONE_HZ(TH), .BEEP_MS(BMS), .GAP_MS(GMS), .NUM_BEEPS(1)
    ) u1 (
        .clk(clk), .rst(rst), .key_flag(kf[1]), .key_value(kv[1]),
        .beep(bp[1]), .busy(bz[1])
    );

    int vectors = 0;
    int miscompares = 0;
    int nb[2] = '{2, 1};
    bit m_act[2];
    bit m_seam[2];
    bit m_pend[2];
    int m_off[2];
    int busy_cnt[2];

    function automatic int total(input int n);
        return n * BEEP + (n - 1) * GAP;
    endfunction

    function automatic bit exp_beep(input int d);
        int r;
        if (!m_act[d] || m_seam[d]) return 1'b0;
        r = m_off[d] % (BEEP + GAP);
        return (r < BEEP) && (((r / HALF) % 2) == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 1'b0;
            m_seam[d] = 1'b0;
            m_pend[d] = 1'b0;
            m_off[d]  = 0;
        end
    endtask

    task automatic model_edge(input int d, input bit trig);
        if (!m_act[d]) begin
            if (trig) begin
                m_act[d] = 1'b1;
                m_off[d] = 0;
            end
        end else if (m_seam[d]) begin
            m_seam[d] = 1'b0;
            m_off[d]  = 0;
            if (QUEUE && trig) m_pend[d] = 1'b1;
        end else if (m_off[d] == total(nb[d]) - 1) begin
            if (QUEUE && (m_pend[d] || trig)) begin
                m_seam[d] = 1'b1;
                m_pend[d] = 1'b0;
            end else begin
                m_act[d] = 1'b0;
            end
        end else begin
            m_off[d]++;
            if (QUEUE && trig) m_pend[d] = 1'b1;
        end
    endtask

    task automatic check(input string tag);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            assert (bp[d] === exp_beep(d)) else begin
                miscompares++;
                $error("FAIL %s beep[%0d] observed %b expected %b",
                       tag, d, bp[d], exp_beep(d));
            end
            vectors++;
            assert (bz[d] === m_act[d]) else begin
                miscompares++;
                $error("FAIL %s busy[%0d] observed %b expected %b",
                       tag, d, bz[d], m_act[d]);
            end
            if (bz[d] === 1'b1) busy_cnt[d]++;
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic step(input logic [1:0] f, input logic [1:0] v, input string tag);
        kf = f;
        kv = v;
        @(posedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) model_edge(d, kf[d] & ~kv[d]);
        end
        @(negedge clk);
        kf = 2'b00;
        kv = 2'b11;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(2'b00, 2'b11, tag);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check("reset");
        rst = 1'b0;
        idle(2, "post_reset");

        busy_cnt = '{0, 0};
        step(2'b11, 2'b00, "press");
        idle(60, "pattern");
        cmp_int("busy_len_2beep", busy_cnt[0], 50);
        cmp_int("busy_len_1beep", busy_cnt[1], 20);

        busy_cnt = '{0, 0};
        step(2'b11, 2'b11, "release");
        idle(10, "release_idle");
        cmp_int("release_busy", busy_cnt[0] + busy_cnt[1], 0);

        busy_cnt = '{0, 0};
        step(2'b01, 2'b00, "press_q");
        idle(24, "burst1_q");
        step(2'b01, 2'b00, "press_gap");
        idle(9, "gap_q");
        step(2'b01, 2'b00, "press_third");
        idle(90, "replay_q");
        cmp_int("busy_len_queue", busy_cnt[0], QUEUE ? 101 : 50);

        step(2'b11, 2'b00, "press_rst");
        idle(12, "burst_rst");
        #2 rst = 1'b1;
        #1 model_reset();
        check("async_rst");
        @(posedge clk);
        @(negedge clk);
        check("rst_held");
        rst = 1'b0;
        idle(1, "rst_release");
        busy_cnt = '{0, 0};
        step(2'b11, 2'b00, "press_after_rst");
        idle(60, "pattern_after_rst");
        cmp_int("busy_after_rst", busy_cnt[0], 50);
        cmp_int("busy_after_rst_1", busy_cnt[1], 20);

        step(2'b11, 2'b00, "press_edge");
        idle(19, "edge_wait1");
        step(2'b10, 2'b00, "final_edge_1beep");
        idle(29, "edge_wait0");
        step(2'b01, 2'b00, "final_edge_2beep");
        idle(110, "edge_tail");

        for (int i = 0; i < 1500; i++) begin
            logic [1:0] f;
            logic [1:0] v;
            f[0] = ($urandom_range(0, 11) == 0);
            f[1] = ($urandom_range(0, 11) == 0);
            v    = 2'($urandom_range(0, 3));
            step(f, v, "random");
        end
        idle(120, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
